// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register bank: address decode, register pointer,
// pointer auto-increment on writes and reads, and an open-drain SDA pull-down.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the 7-bit address + R/W byte
// ADDR_ACK  | pulling SDA low for the address ACK clock
// PTR       | shifting in the register pointer byte
// PTR_ACK   | ACK clock for the pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | ACK clock for a committed write byte
// RDATA     | driving a read byte MSB first, one bit per SCL fall
// RACK      | waiting for the master's ACK/NACK of a read byte
// IGNORE    | not addressed or read ended with NACK; wait for START/STOP
module i2c_reg_target #(
   parameter logic [6:0] TARGET_ADDR = 7'b0011111,
   parameter int         NUM_REGS    = 16,
   parameter int         PTR_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   output logic             wr_strobe,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [7:0]       wr_data,
   output logic             busy,
   input  logic [PTR_W-1:0] dbg_addr,
   output logic [7:0]       dbg_data
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
      ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK, ST_IGNORE
   } state_t;

   state_t           state_q, state_d;
   logic             scl_s1_q, scl_s2_q, scl_p_q, scl_s1_d, scl_s2_d, scl_p_d;
   logic             sda_s1_q, sda_s2_q, sda_p_q, sda_s1_d, sda_s2_d, sda_p_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             rw_q, rw_d;
   logic             ack_on_q, ack_on_d;
   logic             sda_oe_q, sda_oe_d;
   logic             busy_q, busy_d;
   logic             wr_strobe_q, wr_strobe_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic [7:0]       regs_q [NUM_REGS];
   logic [7:0]       regs_d [NUM_REGS];

   logic       scl_rise, scl_fall, bus_start, bus_stop;
   logic [7:0] byte_in, tx_byte, rd_byte;

   assign scl_rise  = scl_s2_q & ~scl_p_q;
   assign scl_fall  = ~scl_s2_q & scl_p_q;
   assign bus_start = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
   assign bus_stop  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
   assign byte_in   = {shreg_q[6:0], sda_s2_q};
   assign rd_byte   = regs_q[ptr_q];
   // bit_cnt of 0 in RDATA means the next fall must fetch a fresh byte
   assign tx_byte   = (bit_cnt_q == 4'd0) ? rd_byte : shreg_q;

   always_comb begin
      scl_s1_d    = scl_i;
      scl_s2_d    = scl_s1_q;
      scl_p_d     = scl_s2_q;
      sda_s1_d    = sda_i;
      sda_s2_d    = sda_s1_q;
      sda_p_d     = sda_s2_q;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      ack_on_d    = ack_on_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      wr_data_d   = wr_data_q;
      regs_d      = regs_q;

      if (bus_start) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 4'd0;
         shreg_d   = 8'h00;
         sda_oe_d  = 1'b0;
         ack_on_d  = 1'b0;
      end else if (bus_stop) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         ack_on_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  shreg_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     if (state_q == ST_ADDR) begin
                        if (byte_in[7:1] == TARGET_ADDR) begin
                           state_d = ST_ADDR_ACK;
                           rw_d    = byte_in[0];
                           busy_d  = 1'b1;
                        end else begin
                           state_d = ST_IGNORE;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == ST_PTR) begin
                        ptr_d   = byte_in[PTR_W-1:0];
                        state_d = ST_PTR_ACK;
                     end else begin
                        wr_strobe_d   = 1'b1;
                        wr_ptr_d      = ptr_q;
                        wr_data_d     = byte_in;
                        regs_d[ptr_q] = byte_in;
                        ptr_d         = ptr_q + PTR_W'(1);
                        state_d       = ST_WDATA_ACK;
                     end
                  end
               end
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               // first fall starts the ACK pulse, second fall ends it
               if (scl_fall) begin
                  if (!ack_on_q) begin
                     ack_on_d = 1'b1;
                     sda_oe_d = 1'b1;
                  end else begin
                     ack_on_d  = 1'b0;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     if (state_q == ST_ADDR_ACK && rw_q) begin
                        state_d   = ST_RDATA;
                        sda_oe_d  = ~rd_byte[7];
                        shreg_d   = {rd_byte[6:0], 1'b0};
                        bit_cnt_d = 4'd1;
                     end else if (state_q == ST_ADDR_ACK) begin
                        state_d = ST_PTR;
                     end else begin
                        state_d = ST_WDATA;
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = ST_RACK;
                  end else begin
                     sda_oe_d  = ~tx_byte[7];
                     shreg_d   = {tx_byte[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_RACK: begin
               if (scl_rise) begin
                  if (!sda_s2_q) begin
                     ptr_d     = ptr_q + PTR_W'(1);
                     bit_cnt_d = 4'd0;
                     state_d   = ST_RDATA;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_IGNORE: sda_oe_d = 1'b0;
            default:   sda_oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s1_q    <= 1'b1;
         scl_s2_q    <= 1'b1;
         scl_p_q     <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
         sda_p_q     <= 1'b1;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         shreg_q     <= 8'h00;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         ack_on_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_ptr_q    <= '0;
         wr_data_q   <= 8'h00;
         regs_q      <= '{default: 8'h00};
      end else begin
         scl_s1_q    <= scl_s1_d;
         scl_s2_q    <= scl_s2_d;
         scl_p_q     <= scl_p_d;
         sda_s1_q    <= sda_s1_d;
         sda_s2_q    <= sda_s2_d;
         sda_p_q     <= sda_p_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         ack_on_q    <= ack_on_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_data_q   <= wr_data_d;
         regs_q      <= regs_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_ptr    = wr_ptr_q;
   assign wr_data   = wr_data_q;
   assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a bit-banged I2C master on an open-drain bus, with a
// scoreboard of expected register commits checked by a separate wr_strobe monitor.
module tb_i2c_reg_target;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       scl_i, sda_i;
   logic       sda_oe, wr_strobe, busy;
   logic [3:0] wr_ptr, dbg_addr;
   logic [7:0] wr_data, dbg_data;

   assign scl_i = scl_m;
   assign sda_i = sda_m & ~sda_oe;

   i2c_reg_target dut (
      .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
      .wr_strobe(wr_strobe), .wr_ptr(wr_ptr), .wr_data(wr_data), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [3:0] p; logic [7:0] d; } wr_t;
   wr_t exp_wr[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;
   int  oe_cnt = 0;

   always @(posedge clk) if (sda_oe === 1'b1) oe_cnt++;

   // Monitor: every commit pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && wr_strobe === 1'b1) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_strobe_unexpected: got ptr=%0d data=%02h, required no commit", wr_ptr, wr_data);
         end else begin
            mon_e = exp_wr.pop_front();
            if (wr_ptr !== mon_e.p || wr_data !== mon_e.d) begin
               errors++;
               $display("FAIL wr_commit: got ptr=%0d data=%02h, required ptr=%0d data=%02h",
                        wr_ptr, wr_data, mon_e.p, mon_e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      #30 sda_m = b;
      #70 scl_m = 1'b1;
      #50 r = sda_i;
      #50 scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      #30 sda_m = 1'b1;
      #70 scl_m = 1'b1;
      #50 sda_m = 1'b0;
      #50 scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      #30 sda_m = 1'b0;
      #70 scl_m = 1'b1;
      #50 sda_m = 1'b1;
      #100;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, r);
      ack = ~r;
   endtask

   task automatic rd_byte(output logic [7:0] d, input logic m_ack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(~m_ack, r);
   endtask

   task automatic send(input logic [7:0] b, input logic exp_ack, input string name);
      logic a;
      wr_byte(b, a);
      chk(name, {31'd0, a}, {31'd0, exp_ack});
   endtask

   task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
      dbg_addr = a;
      #1 chk(name, {24'd0, dbg_data}, {24'd0, exp});
   endtask

   initial begin
      logic [7:0] d;
      logic       r;
      int         c0;
      int         nz;
      dbg_addr = 4'd0;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
      chk("reset_wr_ptr_data", {20'd0, wr_ptr, wr_data}, 32'd0);
      peek(4'd0, 8'h00, "reset_reg0");
      repeat (5) @(negedge clk);

      // single write to reg 5
      exp_wr.push_back('{p: 4'd5, d: 8'h0E});
      i2c_start();
      send(8'h3E, 1'b1, "t1_addr_ack");
      chk("t1_busy_high", {31'd0, busy}, 32'd1);
      send(8'h05, 1'b1, "t1_ptr_ack");
      send(8'h0E, 1'b1, "t1_data_ack");
      i2c_stop();
      chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
      peek(4'd5, 8'h0E, "t1_reg5");

      // pointer write, repeated START, read one byte with NACK
      i2c_start();
      send(8'h3E, 1'b1, "t2_addr_ack");
      send(8'h05, 1'b1, "t2_ptr_ack");
      i2c_start();
      send(8'h3F, 1'b1, "t2_raddr_ack");
      rd_byte(d, 1'b0);
      chk("t2_read_data", {24'd0, d}, 32'h0E);
      #100;
      chk("t2_sda_oe_after_nack", {31'd0, sda_oe}, 32'd0);
      chk("t2_busy_after_nack", {31'd0, busy}, 32'd0);
      i2c_stop();

      // reg 1 = 77, then burst across the wrap
      exp_wr.push_back('{p: 4'd1, d: 8'h77});
      i2c_start();
      send(8'h3E, 1'b1, "t3_addr_ack");
      send(8'h01, 1'b1, "t3_ptr_ack");
      send(8'h77, 1'b1, "t3_data_ack");
      i2c_stop();

      exp_wr.push_back('{p: 4'd14, d: 8'hA1});
      exp_wr.push_back('{p: 4'd15, d: 8'hB2});
      exp_wr.push_back('{p: 4'd0,  d: 8'hC3});
      i2c_start();
      send(8'h3E, 1'b1, "t4_addr_ack");
      send(8'h0E, 1'b1, "t4_ptr_ack");
      send(8'hA1, 1'b1, "t4_d0_ack");
      send(8'hB2, 1'b1, "t4_d1_ack");
      send(8'hC3, 1'b1, "t4_d2_ack");
      i2c_stop();
      peek(4'd14, 8'hA1, "t4_reg14");
      peek(4'd15, 8'hB2, "t4_reg15");
      peek(4'd0,  8'hC3, "t4_reg0");

      // read without a pointer: continues from ptr=1, then auto-increments to 2
      i2c_start();
      send(8'h3F, 1'b1, "t5_raddr_ack");
      rd_byte(d, 1'b1);
      chk("t5_read_ptr1", {24'd0, d}, 32'h77);
      rd_byte(d, 1'b0);
      chk("t5_read_ptr2", {24'd0, d}, 32'h00);
      i2c_stop();

      // foreign address: never drives SDA, never commits
      c0 = oe_cnt;
      i2c_start();
      send(8'hC7, 1'b0, "t6_addr_nack");
      for (int i = 0; i < 8; i++) bit_xfer(i[0], r);
      i2c_stop();
      chk("t6_sda_oe_never", oe_cnt - c0, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      peek(4'd5, 8'h0E, "t6_reg5_kept");

      // STOP mid-byte discards the partial byte; next write commits normally
      i2c_start();
      send(8'h3E, 1'b1, "t7_addr_ack");
      send(8'h02, 1'b1, "t7_ptr_ack");
      bit_xfer(1'b1, r);
      bit_xfer(1'b0, r);
      bit_xfer(1'b1, r);
      bit_xfer(1'b0, r);
      i2c_stop();
      peek(4'd2, 8'h00, "t7_reg2_no_commit");
      exp_wr.push_back('{p: 4'd2, d: 8'h5A});
      i2c_start();
      send(8'h3E, 1'b1, "t7b_addr_ack");
      send(8'h02, 1'b1, "t7b_ptr_ack");
      send(8'h5A, 1'b1, "t7b_data_ack");
      i2c_stop();
      peek(4'd2, 8'h5A, "t7_reg2");

      // reset while driving a 0 bit (reg 3 = 00, ptr = 3)
      i2c_start();
      send(8'h3F, 1'b1, "t8_raddr_ack");
      #50;
      chk("t8_sda_oe_driving", {31'd0, sda_oe}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t8_sda_oe_released", {31'd0, sda_oe}, 32'd0);
      chk("t8_busy_reset", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      nz = 0;
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1 if (dbg_data !== 8'h00) nz++;
      end
      chk("t8_regs_cleared", nz, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      i2c_stop();
      i2c_start();
      send(8'h3F, 1'b1, "t8_post_raddr_ack");
      rd_byte(d, 1'b0);
      chk("t8_post_read_reg0", {24'd0, d}, 32'h00);
      i2c_stop();

      #200;
      chk("commits_outstanding", exp_wr.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got no completion, required finish before 500us");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
- I2C target (responder) with an internal byte-wide register bank.
- It answers the existing I2C master: it decodes the 7-bit address + R/W byte, ACKs its own address and NACKs others.
- It accepts a register-pointer byte, then writes or reads data bytes with pointer auto-increment.
- It sits on the shared SCL/SDA lines beside the memory slave. SDA is open-drain, driven through sda_oe.

Parameters:
- TARGET_ADDR, 7'b0011111, 7-bit address this block answers to (address byte 8'h3E write / 8'h3F read).
- NUM_REGS, 16, number of 8-bit registers; must be a power of two.
- PTR_W, 4, pointer width = log2(NUM_REGS).

Ports:
- clk  input  1  system clock; SCL high and low phases each ≥ 8 clk.
- rst  input  1  synchronous, active-high reset.
- scl_i  input  1  SCL line level.
- sda_i  input  1  SDA line level (resolved bus).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- wr_strobe  output  1  one-clk pulse when a data byte is committed.
- wr_ptr  output  PTR_W  register index of the committed byte.
- wr_data  output  8  committed byte.
- busy  output  1  high from an address match until STOP or NACK-terminated idle.
- dbg_addr  input  PTR_W  debug read index.
- dbg_data  output  8  combinational reg[dbg_addr].

Behaviour:
- Input sampling: scl_i and sda_i pass through 2-flop synchronizers, plus one previous-sample flop for edge detection.
  - SCL rise/fall are detected on synchronized samples.
  - sda_oe updates ≤ 3 clk after a physical SCL falling edge.
- START: synchronized SDA falls while SCL high. Valid in any state, including mid-byte (repeated START).
  - Action: state=ADDR, bit_cnt=0, shift register cleared, sda_oe=0.
- STOP: SDA rises while SCL high. Valid in any state.
  - Action: state=IDLE, sda_oe=0, busy=0; a partial byte is discarded.
- Bit order and timing: bits are MSB first. Received bits are sampled on SCL rising. Driven values change only on SCL falling.
- Address byte: R/W is the LSB (0 = write, 1 = read).
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th rise:
    - match → ADDR_ACK, busy=1.
    - mismatch → IGNORE; sda_oe stays 0 (NACK).
  - ADDR_ACK: sda_oe=1 from the next SCL fall to the following SCL fall.
    - At the release fall: write → PTR; read → RDATA, and the same fall drives bit7 of reg[ptr].
  - PTR: shift 8 bits; ptr = byte[PTR_W-1:0] (upper bits ignored) → PTR_ACK (ACK as above) → WDATA.
  - WDATA: shift 8 bits. On the 8th rise: wr_strobe=1 for one clk with wr_ptr=ptr and wr_data=byte; reg[ptr]=byte; ptr=ptr+1 mod NUM_REGS.
    - Then → WDATA_ACK (ACK) → WDATA.
  - RDATA: sda_oe = ~bit for each bit, set on SCL fall. After the 8th bit's fall window, release at the next SCL fall → RACK.
  - RACK: sample SDA on SCL rise.
    - 0 (ACK) → ptr=ptr+1 mod NUM_REGS, → RDATA, driving the next byte from the next fall.
    - 1 (NACK) → IGNORE.
  - IGNORE: sda_oe=0; leave only on START or STOP.
- Pointer rules:
  - ptr persists across transactions, so a read after a write-with-pointer uses the last pointer.
  - Wrap is NUM_REGS-1 → 0.
- Reset values: state=IDLE, ptr=0, all regs=0, sda_oe=0, wr_strobe=0, wr_ptr=0, wr_data=0, busy=0.
- Reset asserted mid-transaction: same values on the next clk edge; the bus is released immediately.
- START and STOP edges take priority over bit sampling in the same clk.

Test Plan:
- Write: START, 8'h3E, ptr 8'h05, data 8'h0E, STOP → ACK on all three bytes; wr_strobe once with wr_ptr=5 and wr_data=8'h0E; dbg_data at dbg_addr=5 = 8'h0E; ptr=6.
- Read: START, 8'h3E, ptr 8'h05, repeated START, 8'h3F, master reads one byte + NACK, STOP → ACK on addr/ptr; SDA returns 8'h0E; sda_oe=0 after NACK; no wr_strobe.
- Burst wrap: write ptr 8'h0E then data 8'hA1, 8'hB2, 8'hC3 → regs 14,15,0 = A1,B2,C3; ptr=1.
- Wrong address: START, 8'hC7, 8 more clocks of data, STOP → sda_oe never asserted; busy=0; no wr_strobe; registers unchanged.
- Abort: STOP after 4 data bits in WDATA, then a full write to reg 2 → no commit for the partial byte; second transaction commits normally.
- Reset mid-read while sda_oe=1 → sda_oe=0 next clk; all regs read 0; next START+8'h3F returns 8'h00 from reg 0.
